hazard_stall_unit: RTL

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_pkg.sv | 8 +
 rtl/sat_counter.sv | 13 +
 rtl/hazard_stall_unit.sv | 71 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: MDU state encoding and register-match helper shared by the hazard logic.
package hazard_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, WB} mdu_state_e;
    localparam logic [4:0] REG_X0 = 5'd0;
    function automatic logic src_hit(input logic [4:0] src, input logic used, input logic [4:0] rd);
        return used && (src != REG_X0) && (src == rd);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, MDU RAW/structural stall and branch flush control.
module hazard_stall_unit
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_RegWEn,
    input  logic        id_valid,
    input  logic        id_is_load,
    input  logic        id_is_mdu,
    input  logic        ex_branch_taken,
    input  logic        mdu_done,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_flush,
    output logic        if_id_flush,
    output logic        mdu_busy,
    output logic [15:0] stall_cycles
);
    mdu_state_e state, next_state;
    logic       ex_load_valid;
    logic [4:0] ex_load_rd, mdu_rd;
    logic       load_use, mdu_raw, mdu_struct, stall, issue;

    assign load_use   = ex_load_valid && (src_hit(id_rs1, id_rs1_used, ex_load_rd) || src_hit(id_rs2, id_rs2_used, ex_load_rd));
    assign mdu_raw    = state == BUSY && mdu_rd != REG_X0 && (src_hit(id_rs1, id_rs1_used, mdu_rd) || src_hit(id_rs2, id_rs2_used, mdu_rd));
    assign mdu_struct = state == BUSY && id_is_mdu;
    assign stall      = id_valid && !ex_branch_taken && (load_use || mdu_raw || mdu_struct);
    assign issue      = id_valid && !stall && !ex_branch_taken;

    assign pc_stall    = stall;
    assign if_id_stall = stall;
    assign id_ex_flush = stall || ex_branch_taken;
    assign if_id_flush = ex_branch_taken;
    assign mdu_busy    = state == BUSY;

    // A taken branch never cancels BUSY: the MDU op is older than the branch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (issue && id_is_mdu) ? BUSY : IDLE;
            BUSY:    next_state = mdu_done ? WB : BUSY;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            ex_load_valid <= 1'b0;
            ex_load_rd    <= REG_X0;
            mdu_rd        <= REG_X0;
        end else begin
            state         <= next_state;
            ex_load_valid <= issue && id_is_load && id_RegWEn && id_rd != REG_X0;
            if (issue) ex_load_rd <= id_rd;
            if (state == IDLE && issue && id_is_mdu) mdu_rd <= id_rd;
        end

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (stall_cycles)
    );
endmodule
